// File: rtl/hamming_pkg.sv
// Shared types and constant helpers for the Hamming stream encoder.
// HAMMING_SECDED_EN appends an overall-parity bit to every code word.
package hamming_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam int unsigned N_LEGAL = 4;
  localparam int unsigned LEGAL_DATA_W [N_LEGAL] = '{4, 11, 26, 57};

  function automatic logic is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

  function automatic int unsigned par_width(input int unsigned k);
    int unsigned res;
    res = 0;
    for (int unsigned p = 31; p > 0; p--) begin
      if ((32'd1 << p) >= k + p + 1) res = p;
    end
    return res;
  endfunction

  function automatic int unsigned code_width(input int unsigned k);
`ifdef HAMMING_SECDED_EN
    return k + par_width(k) + 1;
`else
    return k + par_width(k);
`endif
  endfunction

  function automatic logic is_legal_data_w(input int unsigned k);
    logic ok;
    ok = 1'b0;
    for (int unsigned i = 0; i < N_LEGAL; i++) begin
      if (LEGAL_DATA_W[i] == k) ok = 1'b1;
    end
    return ok;
  endfunction

  // 1-based code position of data bit idx: the idx-th non-power-of-two position
  function automatic int unsigned data_pos(input int unsigned idx);
    int unsigned cnt;
    int unsigned res;
    cnt = 0;
    res = 0;
    for (int unsigned pos = 1; pos < 128; pos++) begin
      if (!is_pow2(pos)) begin
        if (cnt == idx) res = pos;
        cnt++;
      end
    end
    return res;
  endfunction

  // Data bits covered by parity bit j
  function automatic logic [63:0] data_mask(input int unsigned k, input int unsigned j);
    logic [63:0] m;
    m = '0;
    for (int unsigned idx = 0; idx < k; idx++) begin
      if (((data_pos(idx) >> j) & 32'd1) != 0) m = m | (64'd1 << idx);
    end
    return m;
  endfunction

endpackage

// File: rtl/hamming_parity_gen.sv
// Combinational data -> Hamming SEC code word mapping.
// Under HAMMING_SECDED_EN the MSB carries the XOR of all SEC code bits.
module hamming_parity_gen
  import hamming_pkg::*;
#(
  parameter  int unsigned DATA_W = 4,
  localparam int unsigned PAR_W  = par_width(DATA_W),
  localparam int unsigned SEC_W  = DATA_W + PAR_W,
  localparam int unsigned CODE_W = code_width(DATA_W)
) (
  input  logic [DATA_W-1:0] i_data,
  output logic [CODE_W-1:0] o_code
);

  logic [SEC_W-1:0] w_sec;

  for (genvar i = 0; i < DATA_W; i++) begin : g_data
    assign w_sec[data_pos(i) - 1] = i_data[i];
  end

  for (genvar j = 0; j < PAR_W; j++) begin : g_par
    localparam logic [DATA_W-1:0] MASK = DATA_W'(data_mask(DATA_W, j));
    assign w_sec[(32'd1 << j) - 1] = ^(i_data & MASK);
  end

`ifdef HAMMING_SECDED_EN
  assign o_code = {^w_sec, w_sec};
`else
  assign o_code = w_sec;
`endif

endmodule

// File: rtl/hamming_stream_encoder.sv
// Valid/ready Hamming encoder with one output register, error injection and word counter.
// Build with HAMMING_SECDED_EN to emit SECDED code words.
module hamming_stream_encoder
  import hamming_pkg::*;
#(
  parameter  int unsigned DATA_W = 4,
  parameter  int unsigned CNT_W  = 16,
  localparam int unsigned CODE_W = code_width(DATA_W),
  localparam int unsigned POS_W  = $clog2(CODE_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              inj_en,
  input  logic [POS_W-1:0]  inj_pos,
  output logic [CODE_W-1:0] out_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  word_cnt
);

  if (!is_legal_data_w(DATA_W)) begin : g_bad_data_w
    $error("hamming_stream_encoder: DATA_W must be 4, 11, 26 or 57");
  end

  state_e            r_state;
  state_e            w_state_nxt;
  logic              w_accept;
  logic [CODE_W-1:0] w_code;
  logic [CODE_W-1:0] w_flip;
  logic [CODE_W-1:0] r_code;
  logic [CNT_W-1:0]  r_word_cnt;

  hamming_parity_gen #(.DATA_W(DATA_W)) u_parity_gen (
    .i_data (in_data),
    .o_code (w_code)
  );

  assign in_ready = (r_state == ST_EMPTY) || out_ready;
  assign w_accept = in_valid && in_ready;

  // One-hot flip mask; position 0 and out-of-range positions match no bit
  for (genvar b = 0; b < CODE_W; b++) begin : g_flip
    assign w_flip[b] = inj_en && (inj_pos == POS_W'(b + 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin : state_nxt
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
      ST_FULL:  if (out_ready && !w_accept) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin : code_reg
    if (!rst_n)        r_code <= '0;
    else if (w_accept) r_code <= w_code ^ w_flip;
  end

  always_ff @(posedge clk or negedge rst_n) begin : cnt_reg
    if (!rst_n)        r_word_cnt <= '0;
    else if (w_accept) r_word_cnt <= r_word_cnt + CNT_W'(1);
  end

  assign out_code  = r_code;
  assign out_valid = (r_state == ST_FULL);
  assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_hamming_stream_encoder.sv
// Directed bench: DATA_W=4 vector table plus handshake/reset sequences, DATA_W=11 syndrome sweep.
module tb_hamming_stream_encoder;

`ifdef HAMMING_SECDED_EN
  localparam int unsigned C4  = 8;
  localparam int unsigned C11 = 16;
`else
  localparam int unsigned C4  = 7;
  localparam int unsigned C11 = 15;
`endif
  localparam int unsigned P4  = $clog2(C4 + 1);
  localparam int unsigned P11 = $clog2(C11 + 1);

  typedef struct {
    logic [3:0] data;
    logic       inj_en;
    logic [2:0] inj_pos;
    logic [6:0] exp_sec;
    logic       exp_op;
  } vec_t;

  localparam int N_VEC = 12;
  vec_t vecs [N_VEC];

  int n_tests = 0;
  int n_fail  = 0;

  logic clk = 1'b0;
  logic rst_n;

  logic [3:0]     d4_data;
  logic           d4_valid, d4_ready, d4_inj_en, d4_out_valid, d4_out_ready;
  logic [P4-1:0]  d4_inj_pos;
  logic [C4-1:0]  d4_code;
  logic [3:0]     d4_cnt;

  logic [10:0]    d11_data;
  logic           d11_valid, d11_ready, d11_inj_en, d11_out_valid, d11_out_ready;
  logic [P11-1:0] d11_inj_pos;
  logic [C11-1:0] d11_code;
  logic [15:0]    d11_cnt;

  always #5 clk = ~clk;

  hamming_stream_encoder #(.DATA_W(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(d4_data), .in_valid(d4_valid), .in_ready(d4_ready),
    .inj_en(d4_inj_en), .inj_pos(d4_inj_pos), .out_code(d4_code), .out_valid(d4_out_valid),
    .out_ready(d4_out_ready), .word_cnt(d4_cnt)
  );

  hamming_stream_encoder #(.DATA_W(11), .CNT_W(16)) dut11 (
    .clk(clk), .rst_n(rst_n), .in_data(d11_data), .in_valid(d11_valid), .in_ready(d11_ready),
    .inj_en(d11_inj_en), .inj_pos(d11_inj_pos), .out_code(d11_code), .out_valid(d11_out_valid),
    .out_ready(d11_out_ready), .word_cnt(d11_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [C4-1:0] exp4(input vec_t v);
`ifdef HAMMING_SECDED_EN
    return {v.exp_op, v.exp_sec};
`else
    return v.exp_sec;
`endif
  endfunction

  // Decoder model: XOR of the positions (1..15) of all set bits
  function automatic logic [3:0] syndrome11(input logic [C11-1:0] c);
    logic [3:0] s;
    s = 4'd0;
    for (int p = 1; p <= 15; p++) begin
      if (c[p-1]) s = s ^ 4'(p);
    end
    return s;
  endfunction

  function automatic logic [10:0] extract11(input logic [C11-1:0] c);
    return {c[14], c[13], c[12], c[11], c[10], c[9], c[8], c[6], c[5], c[4], c[2]};
  endfunction

  initial begin
    vecs[0]  = '{4'h0, 1'b0, 3'd0, 7'h00, 1'b0};
    vecs[1]  = '{4'hF, 1'b0, 3'd0, 7'h7F, 1'b1};
    vecs[2]  = '{4'hB, 1'b0, 3'd0, 7'h55, 1'b0};
    vecs[3]  = '{4'hB, 1'b1, 3'd3, 7'h51, 1'b0};
    vecs[4]  = '{4'hB, 1'b1, 3'd0, 7'h55, 1'b0};
    vecs[5]  = '{4'h1, 1'b0, 3'd0, 7'h07, 1'b1};
    vecs[6]  = '{4'h2, 1'b0, 3'd0, 7'h19, 1'b1};
    vecs[7]  = '{4'h4, 1'b0, 3'd0, 7'h2A, 1'b1};
    vecs[8]  = '{4'h8, 1'b0, 3'd0, 7'h4B, 1'b0};
    vecs[9]  = '{4'h8, 1'b1, 3'd7, 7'h0B, 1'b0};
    vecs[10] = '{4'h0, 1'b1, 3'd1, 7'h01, 1'b0};
    vecs[11] = '{4'h0, 1'b0, 3'd5, 7'h00, 1'b0};

    rst_n = 1'b0;
    d4_data = '0; d4_valid = 1'b0; d4_inj_en = 1'b0; d4_inj_pos = '0; d4_out_ready = 1'b1;
    d11_data = '0; d11_valid = 1'b0; d11_inj_en = 1'b0; d11_inj_pos = '0; d11_out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 64'(d4_out_valid), 64'd0);
    chk("rst_out_code",  64'(d4_code),      64'd0);
    chk("rst_word_cnt",  64'(d4_cnt),       64'd0);
    chk("rst_in_ready",  64'(d4_ready),     64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back table at full throughput
    for (int i = 0; i < N_VEC; i++) begin
      d4_data = vecs[i].data; d4_valid = 1'b1;
      d4_inj_en = vecs[i].inj_en; d4_inj_pos = P4'(vecs[i].inj_pos);
      #1;
      chk($sformatf("vec%0d_in_ready", i), 64'(d4_ready), 64'd1);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_code", i),  64'(d4_code),      64'(exp4(vecs[i])));
      chk($sformatf("vec%0d_valid", i), 64'(d4_out_valid), 64'd1);
      if (i == 0) chk("first_word_cnt", 64'(d4_cnt), 64'd1);
    end
    d4_valid = 1'b0; d4_inj_en = 1'b0; d4_inj_pos = '0;
    @(posedge clk); #1;
    chk("drain_valid", 64'(d4_out_valid), 64'd0);
    chk("drain_cnt",   64'(d4_cnt),       64'd12);

    // Backpressure: hold a full register for five cycles
    d4_out_ready = 1'b0; d4_data = 4'hF; d4_valid = 1'b1;
    @(posedge clk); #1;
    d4_data = 4'h1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_in_ready", c), 64'(d4_ready),     64'd0);
      chk($sformatf("bp%0d_code", c),     64'(d4_code),      64'(exp4(vecs[1])));
      chk($sformatf("bp%0d_valid", c),    64'(d4_out_valid), 64'd1);
      @(posedge clk); #1;
    end
    chk("bp_cnt", 64'(d4_cnt), 64'd13);
    d4_out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 64'(d4_ready), 64'd1);
    @(posedge clk); #1;
    chk("bp_next_code", 64'(d4_code), 64'(exp4(vecs[5])));
    chk("bp_next_cnt",  64'(d4_cnt),  64'd14);
    d4_valid = 1'b0;
    @(posedge clk); #1;

    // Three more accepts: 17 in total wraps the 4-bit counter to 1
    for (int i = 6; i <= 8; i++) begin
      d4_data = vecs[i].data; d4_valid = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("wrap%0d_code", i), 64'(d4_code), 64'(exp4(vecs[i])));
    end
    d4_valid = 1'b0;
    chk("wrap_cnt", 64'(d4_cnt), 64'd1);

    // DATA_W=11 exhaustive sweep through the model decoder
    d11_valid = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      d11_data = 11'(i);
      @(posedge clk); #1;
      chk($sformatf("sw%0d_syn", i),  64'(syndrome11(d11_code)), 64'd0);
      chk($sformatf("sw%0d_data", i), 64'(extract11(d11_code)),  64'(i));
`ifdef HAMMING_SECDED_EN
      chk($sformatf("sw%0d_op", i), 64'(^d11_code), 64'd0);
`endif
    end
    d11_data = 11'h5A3; d11_inj_en = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      d11_inj_pos = P11'(k);
      @(posedge clk); #1;
      chk($sformatf("inj%0d_syn", k), 64'(syndrome11(d11_code)), 64'(k));
`ifdef HAMMING_SECDED_EN
      chk($sformatf("inj%0d_op", k), 64'(^d11_code), 64'd1);
`endif
    end
    d11_valid = 1'b0; d11_inj_en = 1'b0;
    chk("sweep_cnt",      64'(d11_cnt),   64'd2063);
    chk("sweep_in_ready", 64'(d11_ready), 64'd1);

    // Reset while a word is pending: clears without a clock edge
    d4_out_ready = 1'b0; d4_data = 4'hB; d4_valid = 1'b1;
    @(posedge clk); #1;
    chk("mid_valid_before", 64'(d4_out_valid), 64'd1);
    chk("mid_cnt_before",   64'(d4_cnt),       64'd2);
    d4_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",    64'(d4_out_valid), 64'd0);
    chk("mid_rst_cnt",      64'(d4_cnt),       64'd0);
    chk("mid_rst_code",     64'(d4_code),      64'd0);
    chk("mid_rst_in_ready", 64'(d4_ready),     64'd1);
    chk("mid_rst_cnt11",    64'(d11_cnt),      64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_stream_encoder.md
Name: hamming_stream_encoder

Overview:
- Parametrised, pipelined Hamming SEC encoder; successor to the fixed 4-bit combinational parity generator.
- Accepts DATA_W-bit words over a valid/ready stream and emits registered code words of CODE_W bits.
- Keeps a running count of encoded words and supports deliberate single-bit error injection for exercising downstream decoders on the board.
- Sits between the switch/data source and the decoder/display path.

Parameters:
- DATA_W, 4, data bits per word; legal values 4, 11, 26, 57 (perfect Hamming sizes); any other value is an elaboration error.
- CNT_W, 16, width of the encoded-word counter.
- PAR_W, derived (localparam), smallest p with 2^p >= DATA_W+p+1; 3 for DATA_W=4.
- CODE_W, derived (localparam), DATA_W+PAR_W, plus 1 when SECDED_EN is defined.

Ports:
- clk, input, 1, system clock; all state on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_data, input, DATA_W, data word to encode.
- in_valid, input, 1, in_data is valid.
- in_ready, output, 1, block accepts in_data this cycle.
- inj_en, input, 1, flip one code bit of the word accepted this cycle.
- inj_pos, input, $clog2(CODE_W+1), 1-based code position to flip; 0 means no flip.
- out_code, output, CODE_W, registered code word.
- out_valid, output, 1, out_code is valid.
- out_ready, input, 1, consumer accepts out_code.
- word_cnt, output, CNT_W, number of words accepted since reset.

Behaviour:
- Reset (async assert, sync-released by the top level): out_valid=0, out_code=0, word_cnt=0. in_ready is combinational and therefore 1 during reset.
- Code layout: positions 1..DATA_W+PAR_W, with out_code bit index = position-1.
  - Parity bit p_j sits at position 2^j.
  - Data bits fill the remaining positions in ascending order, d0 first.
  - p_j = XOR of all data bits whose position has bit j set.
  - For DATA_W=4: out_code = {d3,d2,d1,p2,d0,p1,p0}.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - Accept occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Latency: one cycle. The word accepted at edge N appears on out_code with out_valid=1 after edge N.
- Single output register, two states:
  - EMPTY (out_valid=0): accept -> FULL.
  - FULL, no transfer: hold out_code unchanged; no accept.
  - FULL, transfer with simultaneous accept: reload with the new word and stay FULL. Full throughput is 1 word/cycle.
  - FULL, transfer without accept: -> EMPTY. out_code holds its last value; it is don't-care to the consumer.
- Injection is sampled only on accept.
  - If inj_en=1 and 1 <= inj_pos <= CODE_W, bit inj_pos-1 of the stored word is inverted after parity generation.
  - inj_pos=0 or inj_pos>CODE_W: no flip.
- word_cnt increments by 1 on every accept and wraps from 2^CNT_W-1 to 0 without a flag.
- in_valid deasserted while out_valid=1: out_code is stable until transfer. No data is dropped or duplicated.
- Reset mid-stream: the pending output word is discarded and word_cnt clears.

Optional Feature:
- Macro: HAMMING_SECDED_EN.
- Defined: one overall-parity bit is appended at code bit index DATA_W+PAR_W (MSB). It equals the XOR of all other code bits, computed before injection. Injection may also target this bit at position CODE_W.
- Undefined: CODE_W = DATA_W+PAR_W and SEC-only codes are emitted.

Decomposition:
- Package hamming_pkg:
  - function par_width(k) returning PAR_W;
  - function is_pow2(n);
  - localparam list of legal DATA_W values.
- Sub-module hamming_parity_gen: purely combinational, parametrised by DATA_W. Maps data to the SEC code word (plus overall parity under the macro).
- The top level holds the handshake register, injection logic and counter.

Test Plan:
- DATA_W=4, in_data=4'b1011, out_ready=1 -> out_code=7'h55 one cycle later; word_cnt=1 (with HAMMING_SECDED_EN: 8'h55).
- DATA_W=4, back-to-back 4'h0, 4'hF, 4'hB with out_ready=1 -> out_code 7'h00, 7'h7F, 7'h55 on consecutive cycles, in_ready held at 1 (SECDED: 8'h00, 8'hFF, 8'h55).
- Backpressure: accept 4'hF, hold out_ready=0 for 5 cycles -> in_ready=0, out_code stable at 7'h7F; release -> transfer, then accept the next word.
- Injection: in_data=4'b1011, inj_en=1, inj_pos=3 -> out_code=7'h51. With inj_pos=0 -> out_code=7'h55.
- Counter wrap: CNT_W=4, 17 accepts -> word_cnt=1. Assert rst_n=0 mid-stream -> out_valid=0 and word_cnt=0 immediately, without waiting for a clock edge.
- DATA_W=11 exhaustive sweep of all 2048 inputs -> the model decoder computes syndrome 0 for every word. With inj_pos=k, k=1..15, the syndrome equals k.
